instruction_fetch: RTL and testbench

//  Initiator side of the instruction-ROM read port. It owns the fetch PC and drives
//  rom_address. It captures the combinational ROM word into a small prefetch FIFO and

---
 rtl/instruction_fetch_pkg.sv | 32 +++
 rtl/instruction_fetch_fifo.sv | 74 +++++++
 rtl/instruction_fetch.sv | 108 ++++++++++
 tb/tb_instruction_fetch.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// ============================================================================
//  Module   : instruction_fetch_pkg
//  Purpose  : Shared types and constants for the instruction-fetch slice:
//             ROM byte address, instruction word, and the prefetch FIFO entry.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package instruction_fetch_pkg;

    // Word-address width of the instruction ROM; byte addresses add two bits.
    localparam int WORD_ADDRESS_SIZE = 10;

    typedef logic [WORD_ADDRESS_SIZE+1:0] RomAddress;
    typedef logic [31:0]                  Word;

    typedef struct packed {
        RomAddress pc;
        Word       instr;
    } FetchEntry;

    localparam int INSTR_BYTES = 4;

    // Clears the byte-offset bits so the address points at a whole word.
    function automatic RomAddress align_pc(input RomAddress pc);
        return pc & ~RomAddress'(INSTR_BYTES - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_fifo.sv
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Synchronous prefetch FIFO of FetchEntry. The head slot drives
//             head_o combinationally; flush empties the FIFO at the edge.
//  Ports    : clk, reset (async, active-high)
//             push_i/data_i  write tail      pop_i   advance head
//             flush_i        empty the FIFO  head_o  current head entry
//             full_o/empty_o occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push_i,
    input  FetchEntry data_i,
    input  logic      pop_i,
    input  logic      flush_i,
    output FetchEntry head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    FetchEntry      mem_q [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: slots are only read while the FIFO is non-empty.
    // When full and popping, the tail slot is the head slot being consumed,
    // so overwriting it at the same edge is safe.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
//  Module   : instruction_fetch
//  Purpose  : Initiator side of the instruction-ROM read port. Owns the fetch
//             PC, captures the combinational ROM word into a prefetch FIFO and
//             hands {pc, instr} to decode over valid/ready. Redirects flush.
//  Ports    : clk, reset (async, active-high)
//             rom_address/rom_data         ROM read port (zero latency)
//             out_valid/out_ready          decode handshake
//             out_pc/out_instr             head entry
//             redirect_valid/redirect_pc   control-flow change
//             misaligned                   sticky trap flag (macro only)
//  Config   : `FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter RomAddress RESET_PC   = '0,
    parameter int        FIFO_DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    output RomAddress rom_address,
    input  Word       rom_data,
    output logic      out_valid,
    input  logic      out_ready,
    output RomAddress out_pc,
    output Word       out_instr,
    input  logic      redirect_valid,
    input  RomAddress redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic      misaligned
`endif
);

    RomAddress fetch_pc_q, fetch_pc_d;
    FetchEntry head;
    logic      full, empty;
    logic      pop, push, fetch_block;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q, misaligned_d;

    assign misaligned  = misaligned_q;
    assign fetch_block = misaligned_q;

    always_comb begin
        misaligned_d = misaligned_q;
        if (redirect_valid) begin
            misaligned_d = |redirect_pc[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) misaligned_q <= 1'b0;
        else       misaligned_q <= misaligned_d;
    end
`else
    assign fetch_block = 1'b0;
`endif

    assign rom_address = fetch_pc_q;
    assign out_valid   = !empty;
    assign out_pc      = head.pc;
    assign out_instr   = head.instr;

    // A pop frees a slot at the same edge, so a full FIFO still accepts a push.
    assign pop  = out_valid & out_ready;
    assign push = !redirect_valid & !fetch_block & (!full | pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_pc_d = redirect_pc;
`else
            fetch_pc_d = align_pc(redirect_pc);
`endif
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + RomAddress'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fetch_pc_q <= RESET_PC;
        else       fetch_pc_q <= fetch_pc_d;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  ('{pc: fetch_pc_q, instr: rom_data}),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
//  Module   : tb_instruction_fetch
//  Purpose  : Directed self-checking bench for instruction_fetch with a
//             behavioural word-array ROM holding mem[i] = 0x1000 + i.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic      clk;
    logic      reset;
    RomAddress rom_address;
    Word       rom_data;
    logic      out_valid;
    logic      out_ready;
    RomAddress out_pc;
    Word       out_instr;
    logic      redirect_valid;
    RomAddress redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic      misaligned;
`endif

    Word rom_mem [1 << WORD_ADDRESS_SIZE];
    int  n_checks;
    int  n_errors;

    assign rom_data = rom_mem[rom_address[WORD_ADDRESS_SIZE+1:2]];

    instruction_fetch #(
        .RESET_PC   ('0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_address    (rom_address),
        .rom_data       (rom_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misaligned     (misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expect a valid head entry at byte address pc.
    task automatic expect_entry(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".pc"},    32'(out_pc),    pc);
        check({tag, ".instr"}, out_instr,      32'h1000 + (pc >> 2));
    endtask

    // One-cycle redirect pulse; leaves the bench at the negedge where the
    // flushed FIFO must report empty.
    task automatic do_redirect(input string tag, input RomAddress pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge clk);
        redirect_valid = 1'b0;
        check({tag, ".flushed"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        for (int i = 0; i < (1 << WORD_ADDRESS_SIZE); i++) rom_mem[i] = 32'h1000 + i;
        reset          = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // 1: reset held three cycles, then streaming at one entry per cycle.
        repeat (3) begin
            @(negedge clk);
            check("t1.rst_addr",  32'(rom_address), 32'h0);
            check("t1.rst_valid", 32'(out_valid),   32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        expect_entry("t1.e0", 32'h0);
        @(negedge clk);
        expect_entry("t1.e1", 32'h4);
        @(negedge clk);
        expect_entry("t1.e2", 32'h8);

        // 2: backpressure with a full FIFO, then gap-free drain.
        reset     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_entry("t2.first", 32'h0);
        repeat (5) begin
            @(negedge clk);
            check("t2.hold_addr", 32'(rom_address), 32'h8);
            expect_entry("t2.hold", 32'h0);
        end
        out_ready = 1'b1;
        expect_entry("t2.d0", 32'h0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            expect_entry("t2.dn", 32'(4 * k));
        end

        // 3: redirect while full and draining; no stale entries survive.
        do_redirect("t3", 12'h040);
        check("t3.addr", 32'(rom_address), 32'h40);
        @(negedge clk);
        expect_entry("t3.e0", 32'h40);
        @(negedge clk);
        expect_entry("t3.e1", 32'h44);

        // 4: misaligned redirect target.
        do_redirect("t4", 12'h043);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("t4.trap", 32'(misaligned), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("t4.stall_valid", 32'(out_valid),   32'd0);
            check("t4.stall_addr",  32'(rom_address), 32'h43);
            check("t4.sticky",      32'(misaligned),  32'd1);
        end
        do_redirect("t4b", 12'h020);
        check("t4.clear", 32'(misaligned), 32'd0);
        @(negedge clk);
        expect_entry("t4.e0", 32'h20);
`else
        check("t4.addr", 32'(rom_address), 32'h40);
        @(negedge clk);
        expect_entry("t4.e0", 32'h40);
        @(negedge clk);
        expect_entry("t4.e1", 32'h44);
`endif

        // 5: top word wraps to zero.
        do_redirect("t5", 12'hFFC);
        @(negedge clk);
        expect_entry("t5.top", 32'hFFC);
        @(negedge clk);
        expect_entry("t5.wrap", 32'h0);
        @(negedge clk);
        expect_entry("t5.next", 32'h4);

        // 6: asynchronous reset mid-stream at pc 0x10.
        do_redirect("t6", 12'h008);
        @(negedge clk);
        expect_entry("t6.e0", 32'h8);
        @(negedge clk);
        expect_entry("t6.e1", 32'hC);
        @(negedge clk);
        expect_entry("t6.e2", 32'h10);
        reset = 1'b1;
        #1;
        check("t6.async_valid", 32'(out_valid),   32'd0);
        check("t6.async_addr",  32'(rom_address), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_entry("t6.restart", 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
